// File: rtl/alu_lane_pipe.sv
// One ALU/branch lane: combinational ALU feeding a STAGES-deep EX pipeline with
// global-stall backpressure. Optional signed-overflow trap under ALU_PIPE_OVF_EN.
module alu_lane_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [15:0]       in_imm,
  input  logic              in_extop,
  input  logic              in_alusrc,
  input  logic [2:0]        in_aluop,
  input  logic [1:0]        in_br,
  input  logic              in_regwr,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic              flush_in,
  input  logic              wb_ready,
  output logic              out_valid,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target
`ifdef ALU_PIPE_OVF_EN
  ,
  output logic              ovf_trap,
  output logic [DATA_W-1:0] ovf_pc
`endif
);

  if (STAGES < 1 || STAGES > 4 || DATA_W < 16) begin : g_param_check
    $error("alu_lane_pipe: STAGES must be 1..4 and DATA_W >= 16");
  end

  localparam int MSB = DATA_W - 1;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              msb;
    logic [DATA_W-1:0] target;
    logic [ADDR_W-1:0] dst;
    logic              regwr;
    logic [1:0]        br;
`ifdef ALU_PIPE_OVF_EN
    logic              ovf;
    logic [DATA_W-1:0] pc;
`endif
  } stage_t;

  logic [STAGES-1:0] vld_q, vld_d;
  stage_t            stg_q [STAGES];
  stage_t            stg_d [STAGES];
  stage_t            s1_d;
  stage_t            out_s;

  logic [DATA_W-1:0] sext_imm, ext_imm, opb, alu_res;
  logic              advance, fire, taken, kill;

  // ---------------- ALU in front of stage 1 ----------------
  always_comb begin
    sext_imm = DATA_W'($signed(in_imm));
    ext_imm  = in_extop ? sext_imm : DATA_W'(in_imm);
    opb      = in_alusrc ? ext_imm : in_b;
    alu_res  = '0;
    case (in_aluop)
      3'b000:  alu_res = in_a + opb;
      3'b001:  alu_res = in_a - opb;
      3'b010:  alu_res = in_a & opb;
      3'b011:  alu_res = in_a | opb;
      3'b100:  alu_res = in_a ^ opb;
      3'b101:  alu_res = ~(in_a | opb);
      3'b110:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(in_a) < $signed(opb))};
      default: alu_res = {{(DATA_W-1){1'b0}}, (in_a < opb)};
    endcase
  end

  always_comb begin
    s1_d        = '0;
    s1_d.res    = alu_res;
    s1_d.zero   = (alu_res == '0);
    s1_d.msb    = alu_res[MSB];
    // Target always uses the sign-extended immediate, independent of in_extop.
    s1_d.target = in_pc + DATA_W'(4) + (sext_imm << 2);
    s1_d.dst    = in_dst;
    s1_d.regwr  = in_regwr;
    s1_d.br     = in_br;
`ifdef ALU_PIPE_OVF_EN
    s1_d.pc     = in_pc;
    case (in_aluop)
      3'b000:  s1_d.ovf = (in_a[MSB] == opb[MSB]) && (alu_res[MSB] != in_a[MSB]);
      3'b001:  s1_d.ovf = (in_a[MSB] != opb[MSB]) && (alu_res[MSB] != in_a[MSB]);
      default: s1_d.ovf = 1'b0;
    endcase
`endif
  end

  // ---------------- output stage ----------------
  assign out_s     = stg_q[STAGES-1];
  assign out_valid = vld_q[STAGES-1];
  assign advance   = !out_valid || wb_ready;
  assign in_ready  = advance;
  assign fire      = out_valid && wb_ready;

  always_comb begin
    case (out_s.br)
      2'b01:   taken = out_s.zero;
      2'b10:   taken = !out_s.zero;
      2'b11:   taken = !out_s.msb && !out_s.zero;
      default: taken = 1'b0;
    endcase
  end

  assign br_taken  = fire && taken;
  assign wb_addr   = out_s.dst;
  assign wb_data   = out_s.res;
  assign br_target = out_s.target;

`ifdef ALU_PIPE_OVF_EN
  assign ovf_trap = fire && out_s.ovf;
  assign ovf_pc   = out_s.pc;
  assign wb_en    = out_valid && out_s.regwr && (out_s.br == 2'b00) && !out_s.ovf;
  assign kill     = br_taken || ovf_trap;
`else
  assign wb_en    = out_valid && out_s.regwr && (out_s.br == 2'b00);
  assign kill     = br_taken;
`endif

  // ---------------- pipeline advance / kill ----------------
  // A kill only occurs on a fire cycle, so advance is already 1 then; clearing
  // every valid bit drops the younger ops, the accepted op and refills a bubble.
  always_comb begin
    vld_d = vld_q;
    stg_d = stg_q;
    if (advance) begin
      vld_d[0] = in_valid;
      stg_d[0] = s1_d;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        stg_d[i] = stg_q[i-1];
      end
    end
    if (flush_in || kill) vld_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) stg_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      stg_q <= stg_d;
    end
  end

endmodule

// File: tb/tb_alu_lane_pipe.sv
// Directed bench for alu_lane_pipe: hand-computed vectors, writeback/branch
// scoreboard queues and targeted timing checks. Build with ALU_PIPE_OVF_EN to cover the trap.
module tb_alu_lane_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int STAGES = 3;
  localparam int EW     = ADDR_W + DATA_W;
`ifdef ALU_PIPE_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                         OP_XOR = 3'b100, OP_NOR = 3'b101, OP_SLT = 3'b110, OP_SLTU = 3'b111;

  logic              clk, rst_n;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_pc, in_a, in_b;
  logic [15:0]       in_imm;
  logic              in_extop, in_alusrc, in_regwr;
  logic [2:0]        in_aluop;
  logic [1:0]        in_br;
  logic [ADDR_W-1:0] in_dst;
  logic              flush_in, wb_ready;
  logic              out_valid, wb_en, br_taken;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data, br_target;
`ifdef ALU_PIPE_OVF_EN
  logic              ovf_trap;
  logic [DATA_W-1:0] ovf_pc;
`endif

  alu_lane_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
    .in_extop(in_extop), .in_alusrc(in_alusrc), .in_aluop(in_aluop),
    .in_br(in_br), .in_regwr(in_regwr), .in_dst(in_dst),
    .flush_in(flush_in), .wb_ready(wb_ready),
    .out_valid(out_valid), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .br_taken(br_taken), .br_target(br_target)
`ifdef ALU_PIPE_OVF_EN
    , .ovf_trap(ovf_trap), .ovf_pc(ovf_pc)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] exp_br_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && wb_ready) begin
      if (wb_en) begin
        if (exp_q.size() == 0) check("wb_unexpected", 64'(wb_en), 64'd0);
        else check("wb", 64'({wb_addr, wb_data}), 64'(exp_q.pop_front()));
      end
      if (br_taken) begin
        if (exp_br_q.size() == 0) check("br_unexpected", 64'(br_taken), 64'd0);
        else check("br_target", 64'(br_target), 64'(exp_br_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] imm, input logic alusrc, input logic extop,
                        input logic [1:0] br, input logic regwr, input logic [4:0] dst,
                        input logic [31:0] pc);
    in_aluop = op; in_a = a; in_b = b; in_imm = imm; in_alusrc = alusrc;
    in_extop = extop; in_br = br; in_regwr = regwr; in_dst = dst; in_pc = pc;
  endtask

  task automatic put_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] imm, input logic alusrc, input logic extop,
                        input logic [1:0] br, input logic regwr, input logic [4:0] dst,
                        input logic [31:0] pc);
    logic rdy;
    int   n;
    set_op(op, a, b, imm, alusrc, extop, br, regwr, dst, pc);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 40);
    if (!rdy) check("accept_timeout", 64'(rdy), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic alu_rr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dst);
    put_op(op, a, b, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1, dst, 32'h0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("wait_out_timeout", 64'(out_valid), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] b2b_exp [4];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush_in = 1'b0; wb_ready = 1'b1;
    set_op(OP_ADD, 32'd5, 32'd7, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd3, 32'h0);
    in_valid = 1'b1;

    // Reset with in_valid held high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_wb_en",     64'(wb_en),     64'd0);
    check("rst_br_taken",  64'(br_taken),  64'd0);
    check("rst_wb_addr",   64'(wb_addr),   64'd0);
    check("rst_wb_data",   64'(wb_data),   64'd0);
    check("rst_br_target", 64'(br_target), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back({5'd3, 32'd12});
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      @(negedge clk);
      check("lat_early_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("lat_valid",   64'(out_valid), 64'd1);
    check("lat_wb_en",   64'(wb_en),     64'd1);
    check("lat_wb_addr", 64'(wb_addr),   64'd3);
    check("lat_wb_data", 64'(wb_data),   64'd12);
    tick(STAGES + 2);

    // Back-to-back throughput
    b2b_exp[0] = 32'hFFFF_FFFE; b2b_exp[1] = 32'd1; b2b_exp[2] = 32'd1; b2b_exp[3] = 32'hFFFF_FFFF;
    for (int j = 0; j < 4; j++) exp_q.push_back({5'(4 + j), b2b_exp[j]});
    fork
      begin
        alu_rr(OP_SUB,  32'd3,          32'd5,          5'd4);
        alu_rr(OP_SLTU, 32'd3,          32'hFFFF_FFFF,  5'd5);
        alu_rr(OP_SLT,  32'hFFFF_FFFF,  32'd0,          5'd6);
        alu_rr(OP_NOR,  32'd0,          32'd0,          5'd7);
      end
      begin
        wait_out();
        for (int j = 0; j < 4; j++) begin
          check($sformatf("b2b_valid_%0d", j), 64'(out_valid), 64'd1);
          check($sformatf("b2b_data_%0d", j),  64'(wb_data),   64'(b2b_exp[j]));
          if (j < 3) @(negedge clk);
        end
      end
    join
    tick(STAGES + 2);

    // Stall with an op at the output
    wb_ready = 1'b0;
    exp_q.push_back({5'd8, 32'd3});
    exp_q.push_back({5'd9, 32'd30});
    alu_rr(OP_ADD, 32'd1,  32'd2,  5'd8);
    alu_rr(OP_ADD, 32'd10, 32'd20, 5'd9);
    wait_out();
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", 64'(in_ready),  64'd0);
      check("stall_valid",    64'(out_valid), 64'd1);
      check("stall_addr",     64'(wb_addr),   64'd8);
      check("stall_data",     64'(wb_data),   64'd3);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk);
    #1 wb_ready = 1'b1;
    tick(STAGES + 3);
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // beq taken: younger adds must be squashed
    exp_br_q.push_back(32'h0000_0114);
    fork
      begin
        put_op(OP_SUB, 32'd9, 32'd9, 16'h0004, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0, 32'h100);
        alu_rr(OP_ADD, 32'd1, 32'd1, 5'd10);
        alu_rr(OP_ADD, 32'd2, 32'd2, 5'd11);
      end
      begin
        wait_out();
        check("beq_taken",  64'(br_taken),  64'd1);
        check("beq_target", 64'(br_target), 64'h114);
        check("beq_wb_en",  64'(wb_en),     64'd0);
      end
    join
    tick(STAGES + 3);
    check("beq_squash_valid", 64'(out_valid), 64'd0);

    // bne with equal operands: not taken, adds retire
    exp_q.push_back({5'd10, 32'd2});
    exp_q.push_back({5'd11, 32'd4});
    fork
      begin
        put_op(OP_SUB, 32'd9, 32'd9, 16'h0004, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 32'h100);
        alu_rr(OP_ADD, 32'd1, 32'd1, 5'd10);
        alu_rr(OP_ADD, 32'd2, 32'd2, 5'd11);
      end
      begin
        wait_out();
        check("bne_taken", 64'(br_taken), 64'd0);
        check("bne_wb_en", 64'(wb_en),    64'd0);
      end
    join
    tick(STAGES + 3);
    check("bne_adds_retired", 64'(exp_q.size()), 64'd0);

    // bgtz: negative, positive (negative offset), zero
    put_op(OP_SUB, 32'h8000_0000, 32'd0, 16'h0010, 1'b0, 1'b1, 2'b11, 1'b0, 5'd0, 32'h300);
    wait_out();
    check("bgtz_neg_taken", 64'(br_taken), 64'd0);
    tick(STAGES + 2);
    exp_br_q.push_back(32'h0000_01FC);
    put_op(OP_SUB, 32'd5, 32'd0, 16'hFFFE, 1'b0, 1'b1, 2'b11, 1'b0, 5'd0, 32'h200);
    wait_out();
    check("bgtz_pos_taken",  64'(br_taken),  64'd1);
    check("bgtz_pos_target", 64'(br_target), 64'h1FC);
    tick(STAGES + 2);
    put_op(OP_SUB, 32'd0, 32'd0, 16'h0010, 1'b0, 1'b1, 2'b11, 1'b0, 5'd0, 32'h300);
    wait_out();
    check("bgtz_zero_taken", 64'(br_taken), 64'd0);
    tick(STAGES + 2);

    // Immediates and logic ops through the scoreboard
    exp_q.push_back({5'd14, 32'h0001_000F});
    exp_q.push_back({5'd15, 32'h0000_000F});
    exp_q.push_back({5'd16, 32'h0000_F000});
    exp_q.push_back({5'd17, 32'h0000_FFF0});
    exp_q.push_back({5'd18, 32'h0000_FF00});
    exp_q.push_back({5'd19, 32'd0});
    exp_q.push_back({5'd20, 32'd1});
    put_op(OP_ADD, 32'h10, 32'h0, 16'hFFFF, 1'b1, 1'b0, 2'b00, 1'b1, 5'd14, 32'h0);
    put_op(OP_ADD, 32'h10, 32'h0, 16'hFFFF, 1'b1, 1'b1, 2'b00, 1'b1, 5'd15, 32'h0);
    alu_rr(OP_AND,  32'hF0F0, 32'hFF00,      5'd16);
    alu_rr(OP_OR,   32'hF0F0, 32'h0F00,      5'd17);
    put_op(OP_XOR, 32'hFFFF, 32'h0, 16'h00FF, 1'b1, 1'b0, 2'b00, 1'b1, 5'd18, 32'h0);
    alu_rr(OP_SLT,  32'd5,    32'hFFFF_FFFD, 5'd19);
    alu_rr(OP_SLTU, 32'd5,    32'hFFFF_FFFD, 5'd20);
    put_op(OP_ADD, 32'd1, 32'd1, 16'h0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd21, 32'h0);
    tick(STAGES + 3);
    check("imm_batch_drained", 64'(exp_q.size()), 64'd0);

    // Signed overflow on add, with a younger op behind it
    if (!OVF) exp_q.push_back({5'd21, 32'h8000_0000});
    if (!OVF) exp_q.push_back({5'd22, 32'd6});
    fork
      begin
        put_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd21, 32'h400);
        alu_rr(OP_ADD, 32'd3, 32'd3, 5'd22);
      end
      begin
        wait_out();
        check("ovf_wb_data", 64'(wb_data), 64'h8000_0000);
        check("ovf_wb_en",   64'(wb_en),   64'(!OVF));
`ifdef ALU_PIPE_OVF_EN
        check("ovf_trap",    64'(ovf_trap), 64'd1);
        check("ovf_pc",      64'(ovf_pc),   64'h400);
`endif
      end
    join
    tick(STAGES + 3);
    check("ovf_drained", 64'(exp_q.size()), 64'd0);

    // flush_in while stalled with two ops in flight
    wb_ready = 1'b0;
    alu_rr(OP_ADD, 32'd1, 32'd1, 5'd12);
    alu_rr(OP_ADD, 32'd1, 32'd1, 5'd13);
    wait_out();
    @(posedge clk);
    #1 flush_in = 1'b1;
    @(posedge clk);
    #1 flush_in = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 wb_ready = 1'b1;
    tick(STAGES + 3);
    check("flush_stays_empty", 64'(out_valid), 64'd0);

    // flush_in in the same cycle as a fire: that op still writes back
    exp_q.push_back({5'd23, 32'd2});
    alu_rr(OP_ADD, 32'd1, 32'd1, 5'd23);
    wait_out();
    flush_in = 1'b1;
    check("flush_fire_wb_en", 64'(wb_en), 64'd1);
    @(posedge clk);
    #1 flush_in = 1'b0;
    tick(STAGES + 3);

    check("final_wb_queue", 64'(exp_q.size()),    64'd0);
    check("final_br_queue", 64'(exp_br_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
